// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID latch: owns the PC, absorbs imem latency
// and hazard stalls through a one-entry hold buffer, and applies EX redirects.
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP   = 6'b111111,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] instr_ID,
  output logic [31:0] imemaddr_ID,
  output logic [31:0] next_addr_ID,
  output logic        valid_ID
);

  typedef enum logic [1:0] {FETCH, REDIR, HOLD, HALTED} state_t;
  typedef enum logic [1:0] {ID_KEEP, ID_MEM, ID_BUF, ID_BUBBLE} id_op_t;
  typedef enum logic [1:0] {PC_KEEP, PC_INC, PC_REDIR, PC_TGT} pc_op_t;

  state_t      state, next_state;
  id_op_t      id_op;
  pc_op_t      pc_op;
  logic        tgt_we, buf_we;
  logic [31:0] pc, tgt, hold_buf;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == HALT_OP;
  endfunction

  // 32-bit modulo increment: the top word wraps to zero silently
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign imemaddr = pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (redirect)   next_state = ihit ? FETCH : REDIR;
        else if (stall) next_state = ihit ? HOLD : FETCH;
        else if (ihit)  next_state = is_halt(imemload) ? HALTED : FETCH;
      end
      REDIR:  if (ihit) next_state = FETCH;
      HOLD: begin
        if (redirect)    next_state = FETCH;
        else if (!stall) next_state = is_halt(hold_buf) ? HALTED : FETCH;
      end
      HALTED: if (redirect) next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    imemREN = 1'b0;
    id_op   = ID_KEEP;
    pc_op   = PC_KEEP;
    tgt_we  = 1'b0;
    buf_we  = 1'b0;
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (redirect) begin
          id_op = ID_BUBBLE;
          if (ihit) pc_op  = PC_REDIR;
          else      tgt_we = 1'b1;
        end else if (stall) begin
          buf_we = ihit;
        end else if (ihit) begin
          id_op = ID_MEM;
          pc_op = PC_INC;
        end else begin
          id_op = ID_BUBBLE;
        end
      end
      // the stale request must drain before the new target can be issued
      REDIR: begin
        imemREN = 1'b1;
        id_op   = ID_BUBBLE;
        if (ihit)          pc_op  = redirect ? PC_REDIR : PC_TGT;
        else if (redirect) tgt_we = 1'b1;
      end
      HOLD: begin
        if (redirect) begin
          id_op = ID_BUBBLE;
          pc_op = PC_REDIR;
        end else if (!stall) begin
          id_op = ID_BUF;
          pc_op = PC_INC;
        end
      end
      HALTED: begin
        if (redirect) begin
          id_op = ID_BUBBLE;
          pc_op = PC_REDIR;
        end else if (!stall) begin
          id_op = ID_BUBBLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc           <= PC_INIT;
      instr_ID     <= NOP_INSTR;
      imemaddr_ID  <= 32'd0;
      next_addr_ID <= 32'd0;
      valid_ID     <= 1'b0;
    end else begin
      case (pc_op)
        PC_INC:   pc <= pc_inc(pc);
        PC_REDIR: pc <= redirect_addr;
        PC_TGT:   pc <= tgt;
        default:  pc <= pc;
      endcase
      case (id_op)
        ID_MEM, ID_BUF: begin
          instr_ID     <= (id_op == ID_MEM) ? imemload : hold_buf;
          imemaddr_ID  <= pc;
          next_addr_ID <= pc_inc(pc);
          valid_ID     <= 1'b1;
        end
        ID_BUBBLE: begin
          instr_ID     <= NOP_INSTR;
          imemaddr_ID  <= 32'd0;
          next_addr_ID <= 32'd0;
          valid_ID     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // tgt and hold_buf are only read when the state says they are live
  always_ff @(posedge CLK) begin
    if (tgt_we) tgt      <= redirect_addr;
    if (buf_we) hold_buf <= imemload;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a flag-based reference model checked every
// cycle, plus hand-computed expectations along the directed sequence.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'd0;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr_ID, imemaddr_ID, next_addr_ID;
  logic        valid_ID;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_ID(instr_ID), .imemaddr_ID(imemaddr_ID),
    .next_addr_ID(next_addr_ID), .valid_ID(valid_ID)
  );

  always #5 CLK = ~CLK;

  // instruction memory contents: HALT at 0x20, addi-like word at 0xC
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h20) return 32'hFFFF_FFFF;
    if (a == 32'hC)  return 32'h2001_0005;
    return 32'h0800_0000 | (a >> 2);
  endfunction

  assign imemload = word(imemaddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending redirect, buffered word, halted flag
  logic [31:0] m_pc = 32'd0, m_tgt = 32'd0, m_buf = 32'd0;
  bit          m_pend = 0, m_hasbuf = 0, m_halted = 0;
  logic [31:0] m_instr = 32'd0, m_addr = 32'd0, m_next = 32'd0;
  bit          m_valid = 0;

  task automatic m_bubble();
    m_instr = 32'd0; m_addr = 32'd0; m_next = 32'd0; m_valid = 0;
  endtask

  task automatic m_load(input logic [31:0] w);
    m_instr = w; m_addr = m_pc; m_next = m_pc + 32'd4; m_valid = 1;
    m_pc = m_pc + 32'd4;
    m_halted = (w[31:26] == 6'b111111);
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc = 32'd0; m_pend = 0; m_hasbuf = 0; m_halted = 0;
      m_bubble();
    end else if (redirect) begin
      m_bubble();
      if (m_pend) begin
        if (ihit) begin m_pc = redirect_addr; m_pend = 0; end
        else m_tgt = redirect_addr;
      end else if (m_hasbuf || m_halted || ihit) begin
        m_hasbuf = 0; m_halted = 0; m_pc = redirect_addr;
      end else begin
        m_pend = 1; m_tgt = redirect_addr;
      end
    end else if (m_pend) begin
      m_bubble();
      if (ihit) begin m_pc = m_tgt; m_pend = 0; end
    end else if (m_hasbuf) begin
      if (!stall) begin m_hasbuf = 0; m_load(m_buf); end
    end else if (m_halted) begin
      if (!stall) m_bubble();
    end else if (stall) begin
      if (ihit) begin m_hasbuf = 1; m_buf = imemload; end
    end else if (ihit) begin
      m_load(imemload);
    end else begin
      m_bubble();
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      chk("m_imemREN", imemREN, (m_hasbuf || m_halted) ? 1'b0 : 1'b1);
      chk("m_imemaddr", imemaddr, m_pc);
      chk("m_instr_ID", instr_ID, m_instr);
      chk("m_imemaddr_ID", imemaddr_ID, m_addr);
      chk("m_next_addr_ID", next_addr_ID, m_next);
      chk("m_valid_ID", valid_ID, m_valid);
    end
  end

  task automatic step(input bit h, input bit s, input bit r, input logic [31:0] ra);
    ihit = h; stall = s; redirect = r; redirect_addr = ra;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_id(input string tag, input logic [31:0] ins, input logic [31:0] a, input bit v);
    chk({tag, "_instr"}, instr_ID, ins);
    chk({tag, "_addr"}, imemaddr_ID, a);
    chk({tag, "_next"}, next_addr_ID, v ? a + 32'd4 : 32'd0);
    chk({tag, "_valid"}, valid_ID, v);
  endtask

  initial begin
    @(posedge CLK); #1;
    chk("rst_imemREN", imemREN, 1'b1);
    chk("rst_imemaddr", imemaddr, 32'd0);
    expect_id("rst", 32'd0, 32'd0, 0);
    @(negedge CLK); nRST = 1'b1; run = 1'b1;

    // T1: back-to-back hits
    step(1, 0, 0, 0); expect_id("t1a", 32'h0800_0000, 32'h0, 1);
    step(1, 0, 0, 0); expect_id("t1b", 32'h0800_0001, 32'h4, 1);
    chk("t1_pc", imemaddr, 32'h8);
    // T2: three missing cycles, then the word at 8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t2_valid", valid_ID, 1'b0);
      chk("t2_pc", imemaddr, 32'h8);
    end
    step(1, 0, 0, 0); expect_id("t2", 32'h0800_0002, 32'h8, 1);
    // T3: stall on the hit at C, hold two cycles
    step(1, 1, 0, 0);
    chk("t3_ren_a", imemREN, 1'b0); expect_id("t3a", 32'h0800_0002, 32'h8, 1);
    step(0, 1, 0, 0);
    chk("t3_ren_b", imemREN, 1'b0); expect_id("t3b", 32'h0800_0002, 32'h8, 1);
    step(0, 0, 0, 0);
    expect_id("t3c", 32'h2001_0005, 32'hC, 1);
    chk("t3_pc", imemaddr, 32'h10);
    chk("t3_ren_c", imemREN, 1'b1);
    // T4: redirect while the request is outstanding
    step(0, 0, 1, 32'h40);
    chk("t4_valid_a", valid_ID, 1'b0); chk("t4_pc_a", imemaddr, 32'h10);
    step(0, 0, 0, 0);
    chk("t4_valid_b", valid_ID, 1'b0); chk("t4_pc_b", imemaddr, 32'h10);
    step(1, 0, 0, 0);
    chk("t4_valid_c", valid_ID, 1'b0); chk("t4_pc_c", imemaddr, 32'h40);
    // T5: redirect-with-hit to 0x18, run into HALT at 0x20
    step(1, 0, 1, 32'h18); chk("t5_pc_a", imemaddr, 32'h18);
    step(1, 0, 0, 0); expect_id("t5a", 32'h0800_0006, 32'h18, 1);
    step(1, 0, 0, 0); expect_id("t5b", 32'h0800_0007, 32'h1C, 1);
    step(1, 0, 0, 0); expect_id("t5c", 32'hFFFF_FFFF, 32'h20, 1);
    chk("t5_ren_a", imemREN, 1'b0);
    step(1, 0, 0, 0); chk("t5_valid", valid_ID, 1'b0); chk("t5_ren_b", imemREN, 1'b0);
    step(0, 0, 1, 32'h80); chk("t5_pc_b", imemaddr, 32'h80); chk("t5_ren_c", imemREN, 1'b1);
    step(1, 0, 0, 0); expect_id("t5d", 32'h0800_0020, 32'h80, 1);
    // second redirect while pending: last one wins
    step(0, 0, 1, 32'h100);
    step(0, 0, 1, 32'h200);
    step(1, 0, 0, 0); chk("lastwin_pc", imemaddr, 32'h200); chk("lastwin_valid", valid_ID, 1'b0);
    // redirect out of HOLD to the top word, then wrap
    step(1, 1, 0, 0); chk("holdr_ren", imemREN, 1'b0);
    step(0, 0, 1, 32'hFFFF_FFFC); chk("holdr_pc", imemaddr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("wrap_instr", instr_ID, 32'h3FFF_FFFF);
    chk("wrap_next", next_addr_ID, 32'h0);
    chk("wrap_pc", imemaddr, 32'h0);
    // T6: asynchronous reset in the middle of HOLD
    step(1, 0, 0, 0);
    step(1, 1, 0, 0); chk("t6_ren_hold", imemREN, 1'b0); chk("t6_pc_hold", imemaddr, 32'h4);
    ihit = 1'b0; stall = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("t6_ren", imemREN, 1'b1);
    chk("t6_pc", imemaddr, 32'h0);
    expect_id("t6", 32'd0, 32'd0, 0);
    @(negedge CLK); nRST = 1'b1;
    step(1, 0, 0, 0); expect_id("t6_after", 32'h0800_0000, 32'h0, 1);
    step(0, 0, 0, 0);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
